// File: rtl/lfsr_range_generator.sv
// Parametrised XNOR-LFSR random source with seed reload, lockup guard
// and bounded-range output by rejection sampling behind a valid/ready port.
module lfsr_range_generator #(
  parameter int WIDTH = 11,
  parameter logic [WIDTH-1:0] TAPS = 11'h682,
  parameter int OUT_BITS = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [WIDTH-1:0]    seed,
  input  logic                seed_load,
  input  logic [OUT_BITS-1:0] limit,
  input  logic                ready,
  output logic                valid,
  output logic [OUT_BITS-1:0] rnd_out,
  output logic [WIDTH-1:0]    lfsr_state,
  output logic                lockup_flag,
  output logic [CNT_BITS-1:0] reject_cnt
);

  localparam logic [WIDTH-1:0] LOCKUP = '1;

  logic [WIDTH-1:0]    state_q, state_d;
  logic                valid_q, valid_d;
  logic [OUT_BITS-1:0] rnd_q, rnd_d;
  logic                lock_q, lock_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                fb;
  logic [WIDTH-1:0]    next_state;
  logic [OUT_BITS-1:0] cand;
  logic                in_range;
  logic                step;
  logic                seed_lock;
  logic [WIDTH-1:0]    seed_val;
  logic                cnt_sat;

  // All-ones is the XNOR fixed point, so it is swapped for all-zeros.
  assign seed_lock = (seed == LOCKUP);
  assign seed_val  = seed_lock ? '0 : seed;

  assign fb         = ~^(state_q & TAPS);
  assign next_state = {state_q[WIDTH-2:0], fb};
  assign cand       = next_state[OUT_BITS-1:0];
  assign in_range   = (limit == '0) || (cand < limit);
  assign cnt_sat    = &cnt_q;

  // Holding the LFSR under backpressure keeps the accepted
  // sequence independent of the consumer's ready pattern.
  assign step = en && (!valid_q || ready);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    rnd_d   = rnd_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    if (seed_load) begin
      state_d = seed_val;
      lock_d  = seed_lock;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (step) begin
      state_d = next_state;
      if (in_range) begin
        rnd_d   = cand;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
        if (!cnt_sat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= seed_val;
      lock_q  <= seed_lock;
      valid_q <= 1'b0;
      rnd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      rnd_q   <= rnd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid       = valid_q;
  assign rnd_out     = rnd_q;
  assign lfsr_state  = state_q;
  assign lockup_flag = lock_q;
  assign reject_cnt  = cnt_q;

endmodule

// File: tb/tb_lfsr_range_generator.sv
// Directed bench for lfsr_range_generator: main instance plus a
// narrow-counter instance for saturation.
module tb_lfsr_range_generator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, seed_load, ready;
  logic [10:0] seed;
  logic [3:0]  limit;
  logic        valid, lockup_flag;
  logic [3:0]  rnd_out;
  logic [10:0] lfsr_state;
  logic [15:0] reject_cnt;

  logic        s_rst, s_en, s_seed_load, s_ready;
  logic [10:0] s_seed;
  logic [3:0]  s_limit;
  logic        s_valid, s_lockup_flag;
  logic [3:0]  s_rnd_out;
  logic [10:0] s_lfsr_state;
  logic [1:0]  s_reject_cnt;

  int nvec = 0;
  int nerr = 0;

  lfsr_range_generator u_dut (
    .clk(clk), .rst(rst), .en(en), .seed(seed),
    .seed_load(seed_load), .limit(limit), .ready(ready),
    .valid(valid), .rnd_out(rnd_out), .lfsr_state(lfsr_state),
    .lockup_flag(lockup_flag), .reject_cnt(reject_cnt)
  );

  lfsr_range_generator #(.CNT_BITS(2)) u_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .seed(s_seed),
    .seed_load(s_seed_load), .limit(s_limit), .ready(s_ready),
    .valid(s_valid), .rnd_out(s_rnd_out), .lfsr_state(s_lfsr_state),
    .lockup_flag(s_lockup_flag), .reject_cnt(s_reject_cnt)
  );

  logic [10:0] exp_st [4] = '{11'h255, 11'h4AA, 11'h154, 11'h2A9};
  logic [3:0]  exp_rn [4] = '{4'd5, 4'd10, 4'd4, 4'd9};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [10:0] s);
    rst = 1'b0; en = 1'b0; seed_load = 1'b0; seed = s;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; seed_load = 1'b0; ready = 1'b1;
    limit = 4'd0; seed = 11'h52A;
    tick();
    nvec++;
    if (lfsr_state !== 11'h52A) begin
      nerr++; $display("FAIL reset_state got=%h exp=52a", lfsr_state);
    end
    nvec++;
    if (valid !== 1'b0 || rnd_out !== 4'd0 || reject_cnt !== 16'd0
        || lockup_flag !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outs v=%b r=%0d c=%0d l=%b exp 0/0/0/0",
               valid, rnd_out, reject_cnt, lockup_flag);
    end
  endtask

  task automatic test_free_run();
    rst = 1'b1; en = 1'b1; ready = 1'b1; limit = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++;
      if (lfsr_state !== exp_st[i] || valid !== 1'b1
          || rnd_out !== exp_rn[i] || reject_cnt !== 16'd0) begin
        nerr++;
        $display("FAIL free_run[%0d] st=%h v=%b r=%0d c=%0d exp st=%h v=1 r=%0d c=0",
                 i, lfsr_state, valid, rnd_out, reject_cnt, exp_st[i], exp_rn[i]);
      end
    end
  endtask

  task automatic test_limit();
    logic ev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset(11'h52A);
    en = 1'b1; ready = 1'b1; limit = 4'd8;
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++;
      if (valid !== ev[i] || lfsr_state !== exp_st[i]
          || (ev[i] && rnd_out !== exp_rn[i])) begin
        nerr++;
        $display("FAIL limit8[%0d] v=%b r=%0d st=%h exp v=%b r=%0d st=%h",
                 i, valid, rnd_out, lfsr_state, ev[i], exp_rn[i], exp_st[i]);
      end
    end
    nvec++;
    if (reject_cnt !== 16'd2) begin
      nerr++; $display("FAIL limit8_rejects got=%0d exp=2", reject_cnt);
    end
    limit = 4'd0;
  endtask

  task automatic test_backpressure();
    logic        rp [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int          got = 0;
    logic        held;
    logic [10:0] hs;
    logic [3:0]  hr;
    do_reset(11'h52A);
    en = 1'b1; limit = 4'd0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      ready = (i < 8) ? rp[i] : 1'b1;
      held = valid && !ready;
      hs = lfsr_state; hr = rnd_out;
      if (valid && ready) begin
        nvec++;
        if (rnd_out !== exp_rn[got]) begin
          nerr++;
          $display("FAIL bp_accept[%0d] got=%0d exp=%0d", got, rnd_out, exp_rn[got]);
        end
        got++;
      end
      tick();
      if (held) begin
        nvec++;
        if (lfsr_state !== hs || rnd_out !== hr || valid !== 1'b1) begin
          nerr++;
          $display("FAIL bp_hold st=%h r=%0d v=%b exp st=%h r=%0d v=1",
                   lfsr_state, rnd_out, valid, hs, hr);
        end
      end
    end
    nvec++;
    if (got != 4) begin
      nerr++; $display("FAIL bp_count got=%0d exp=4", got);
    end
    ready = 1'b1;
  endtask

  task automatic test_enable_hold();
    do_reset(11'h52A);
    en = 1'b1; ready = 1'b1; limit = 4'd0;
    tick();
    en = 1'b0; ready = 1'b0;
    tick();
    nvec++;
    if (valid !== 1'b1 || rnd_out !== 4'd5 || lfsr_state !== 11'h255) begin
      nerr++;
      $display("FAIL en_hold v=%b r=%0d st=%h exp 1/5/255", valid, rnd_out, lfsr_state);
    end
    ready = 1'b1;
    tick();
    nvec++;
    if (valid !== 1'b0 || rnd_out !== 4'd5 || lfsr_state !== 11'h255) begin
      nerr++;
      $display("FAIL en_drain v=%b r=%0d st=%h exp 0/5/255", valid, rnd_out, lfsr_state);
    end
  endtask

  task automatic test_lockup();
    en = 1'b1; ready = 1'b1; limit = 4'd0;
    seed = 11'h7FF; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    nvec++;
    if (lfsr_state !== 11'h000 || lockup_flag !== 1'b1 || valid !== 1'b0) begin
      nerr++;
      $display("FAIL lockup_load st=%h l=%b v=%b exp 000/1/0",
               lfsr_state, lockup_flag, valid);
    end
    tick();
    nvec++;
    if (lfsr_state !== 11'h001 || rnd_out !== 4'd1 || valid !== 1'b1
        || lockup_flag !== 1'b1) begin
      nerr++;
      $display("FAIL lockup_step st=%h r=%0d v=%b l=%b exp 001/1/1/1",
               lfsr_state, rnd_out, valid, lockup_flag);
    end
    seed = 11'h52A; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    nvec++;
    if (lockup_flag !== 1'b0 || lfsr_state !== 11'h52A || valid !== 1'b0) begin
      nerr++;
      $display("FAIL lockup_clear l=%b st=%h v=%b exp 0/52a/0",
               lockup_flag, lfsr_state, valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(11'h52A);
    en = 1'b1; ready = 1'b1; limit = 4'd8;
    for (int i = 0; i < 3; i++) tick();
    nvec++;
    if (valid !== 1'b1 || rnd_out !== 4'd4 || reject_cnt !== 16'd1) begin
      nerr++;
      $display("FAIL mid_pre v=%b r=%0d c=%0d exp 1/4/1", valid, rnd_out, reject_cnt);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1; limit = 4'd0;
    nvec++;
    if (valid !== 1'b0 || rnd_out !== 4'd0 || reject_cnt !== 16'd0
        || lfsr_state !== 11'h52A) begin
      nerr++;
      $display("FAIL mid_reset v=%b r=%0d c=%0d st=%h exp 0/0/0/52a",
               valid, rnd_out, reject_cnt, lfsr_state);
    end
    tick();
    nvec++;
    if (valid !== 1'b1 || rnd_out !== 4'd5) begin
      nerr++; $display("FAIL mid_restart v=%b r=%0d exp 1/5", valid, rnd_out);
    end
  endtask

  task automatic test_saturation();
    logic [10:0] ss [10] = '{11'h001, 11'h003, 11'h006, 11'h00C, 11'h019,
                             11'h033, 11'h066, 11'h0CC, 11'h198, 11'h330};
    logic [1:0] ec;
    s_rst = 1'b0; s_en = 1'b0; s_seed_load = 1'b0; s_ready = 1'b1;
    s_seed = 11'h7FF; s_limit = 4'd1;
    tick();
    nvec++;
    if (s_lfsr_state !== 11'h000 || s_lockup_flag !== 1'b1) begin
      nerr++;
      $display("FAIL sat_reset st=%h l=%b exp 000/1", s_lfsr_state, s_lockup_flag);
    end
    s_rst = 1'b1; s_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      ec = (k >= 2) ? 2'd3 : 2'(k + 1);
      nvec++;
      if (s_lfsr_state !== ss[k] || s_reject_cnt !== ec
          || s_valid !== (k == 9) || (s_valid && s_rnd_out !== 4'd0)) begin
        nerr++;
        $display("FAIL sat[%0d] st=%h c=%0d v=%b r=%0d exp st=%h c=%0d v=%b r=0",
                 k, s_lfsr_state, s_reject_cnt, s_valid, s_rnd_out,
                 ss[k], ec, (k == 9));
      end
    end
    s_en = 1'b0;
  endtask

  initial begin
    s_rst = 1'b0; s_en = 1'b0; s_seed_load = 1'b0; s_ready = 1'b1;
    s_seed = 11'h001; s_limit = 4'd0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_limit();
    test_backpressure();
    test_enable_hold();
    test_lockup();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lfsr_range_generator.md
Name: lfsr_range_generator

Overview:
- Parametrised successor to the fixed 11-bit XNOR-LFSR random generator used by the simulated-annealing engine.
- Adds four things: generic width and taps, runtime seed reload, lockup protection, and bounded-range output by rejection sampling.
- Output uses a valid/ready handshake with a one-entry output register.
- Consumers are the SA cell/swap selectors, which need uniform indices in [0, limit).

Parameters:
- WIDTH, 11, LFSR state width (>=3).
- TAPS, 11'h682, feedback tap mask over state bits (default taps 10, 9, 7, 1).
- OUT_BITS, 4, width of the random output; taken from state[OUT_BITS-1:0]; must be <= WIDTH.
- CNT_BITS, 16, width of the saturating reject counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- en  in  1  generator enable; LFSR steps only when 1.
- seed  in  WIDTH  seed value, loaded on reset and on seed_load.
- seed_load  in  1  single-cycle reseed and flush request.
- limit  in  OUT_BITS  exclusive upper bound of the output range; 0 means full range 2^OUT_BITS.
- ready  in  1  consumer accepts rnd_out this cycle.
- valid  out  1  rnd_out holds an accepted value.
- rnd_out  out  OUT_BITS  random value.
- lfsr_state  out  WIDTH  current LFSR state (debug).
- lockup_flag  out  1  sticky; the seed was the lockup value and was substituted.
- reject_cnt  out  CNT_BITS  saturating count of rejected candidates.

Behaviour:
- Feedback: fb = ~^(state & TAPS), i.e. the XNOR of the tapped bits.
- Next state: {state[WIDTH-2:0], fb}.
- Lockup value: all-ones. Any seed equal to all-ones is loaded as all-zeros and sets lockup_flag.
- Reset (rst==0 at a rising edge):
  - state <= seed (with lockup substitution); lockup_flag set accordingly.
  - valid=0, rnd_out=0, reject_cnt=0.
  - Reset has priority over every other input.
- seed_load (rst==1):
  - state <= seed (with substitution); lockup_flag updated from this seed.
  - valid <= 0, reject_cnt <= 0, no step this cycle.
  - Has priority over en and ready; any pending output is discarded.
- Step condition: step = en && (!valid || ready). While valid && !ready the LFSR holds.
  - Consequence: the accepted sequence is independent of the ready pattern.
- On step:
  - state <= next; candidate c = next[OUT_BITS-1:0].
  - Accept c if limit==0 or c < limit (unsigned).
  - Accept: rnd_out <= c, valid <= 1.
  - Reject: valid <= 0 (rnd_out may keep its old value), reject_cnt <= reject_cnt+1, saturating at all-ones.
- No step, with valid && ready: valid <= 0 (consumer drained, en=0).
- No step, otherwise: valid and rnd_out hold.
- Latency: a value appears on the edge that performs its step, so valid rises one cycle after the first enabled cycle.
- Throughput: one value per cycle when every candidate is accepted and ready=1.
- limit is sampled combinationally each stepping cycle. Changing it affects only future candidates, never a value already held.
- Simultaneous seed_load and ready with valid=1: the held value counts as consumed. Bench must not score it twice.
- Reset mid-operation discards the held output with no partial update.
- en=0: state, rnd_out and reject_cnt frozen; valid can still drop via ready.
- lockup_flag is cleared only by a reset or seed_load with a non-lockup seed.

Test Plan:
- Reset, seed=11'h52A, limit=0, ready=1, en=1 from first cycle:
  - lfsr_state 0x255, 0x4AA, 0x154, 0x2A9 on successive edges.
  - rnd_out 5, 10, 4, 9 with valid=1 each cycle; reject_cnt=0.
- Same seed, limit=8:
  - accepted outputs 5 then 4 (valid low on the 10 and 9 cycles).
  - reject_cnt=2 after four steps.
- Backpressure: same seed, limit=0, ready toggled 1,0,0,1,1:
  - accepted sequence still 5, 10, 4, 9.
  - lfsr_state and rnd_out stable while valid && !ready.
- Lockup: seed_load with seed=11'h7FF:
  - lfsr_state=0, lockup_flag=1, valid=0.
  - next step gives state 0x001, rnd_out=1.
  - seed_load of 0x52A clears lockup_flag.
- Reset mid-stream: rst=0 for one edge while valid=1:
  - valid=0, rnd_out=0, reject_cnt=0, state=seed.
  - sequence restarts at 5.
- Saturation: CNT_BITS=2, limit=1, run until 4+ rejects:
  - reject_cnt holds 3 and never wraps.
  - only candidates equal to 0 are output.
